div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have the following parameter: DIV_STEPS, 32, number of quotient bits produced (one per clock).
REQ-002 SHALL have the following ports:
clk  input  1  single clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset.
divControl  input  2  command: 00 idle, 01 start, 11 abort, 10 reserved (treated as 00).
aIn  input  32  dividend, signed two's complement; sampled only on accepted start.
bIn  input  32  divisor, signed two's complement; sampled only on accepted start.
hiOut  output  32  remainder register (HI).
loOut  output  32  quotient register (LO).
divBusy  output  1  high while an operation is in progress.
divDone  output  1  one-cycle pulse when hiOut/loOut are updated.
div0  output  1  one-cycle pulse on start with bIn == 0.

Function
REQ-003 SHALL implement states IDLE, CALC and DONE.
REQ-004 SHALL accept start (divControl==01) only in IDLE; start in CALC/DONE is ignored.
REQ-005 On accepted start with bIn==0 SHALL pulse div0 high for exactly the next cycle, stay IDLE, and leave hiOut/loOut unchanged.
REQ-006 On accepted start with bIn!=0 SHALL latch |aIn|, |bIn| as 32-bit unsigned magnitudes plus sign(aIn), sign(aIn) XOR sign(bIn), clear step counter, enter CALC.
REQ-007 In CALC SHALL perform one restoring-division step per clock (shift remainder:dividend left 1, trial-subtract |divisor|, keep if non-negative, quotient bit = 1 if kept).
REQ-008 SHALL leave CALC for DONE on the edge completing step DIV_STEPS; counter wraps to 0 only via a new start.
REQ-009 On the DONE edge SHALL write loOut = quotient, negated if signs differ; hiOut = remainder, negated if dividend negative; then assert divDone for exactly one cycle and return to IDLE.
REQ-010 Latency: start sampled at edge N -> hiOut/loOut updated and divDone high after edge N+33; divBusy high after edges N+1..N+32 inclusive, low from edge N+33.
REQ-011 SHALL compute 0x80000000 / 0xFFFFFFFF as loOut=0x80000000, hiOut=0 (wrap, no flag).
REQ-012 Abort (divControl==11) in CALC or DONE SHALL return to IDLE on next edge, hiOut/loOut unchanged, no divDone; abort in IDLE has no effect.
REQ-013 Abort has priority over step completion on the same edge.
REQ-014 divDone and div0 SHALL never be high in the same cycle.
REQ-015 A start may be accepted in the cycle divDone is high (state is IDLE).

Reset
REQ-016 reset low SHALL immediately force IDLE, counter 0, hiOut=0, loOut=0, divBusy=0, divDone=0, div0=0 regardless of clk.
REQ-017 Reset asserted mid-CALC SHALL discard the operation; no divDone after release.
REQ-018 After reset release, first rising edge with divControl==01 SHALL be accepted.

Verification
REQ-019 aIn=100, bIn=7, start at edge N -> edge N+33: loOut=14, hiOut=2, divDone pulse one cycle.
REQ-020 aIn=-100, bIn=7 -> loOut=0xFFFFFFF2, hiOut=0xFFFFFFFE; aIn=100, bIn=-7 -> loOut=0xFFFFFFF2, hiOut=2.
REQ-021 After a 100/7 result, aIn=5, bIn=0 start -> div0 high one cycle, divBusy stays 0, hiOut=2, loOut=14 retained.
REQ-022 aIn=0x80000000, bIn=0xFFFFFFFF -> loOut=0x80000000, hiOut=0, no div0.
REQ-023 Start 100/7, abort 10 cycles later -> IDLE next edge, no divDone, outputs unchanged; second start while busy (edge N+5, aIn=9, bIn=3) ignored, result still 14/2.
REQ-024 Start 100/7, pull reset low mid-cycle at step 20 -> outputs 0 immediately, no divDone after release; fresh start completes in 33 cycles.

Source files
------------

// File: rtl/div_unit.sv
// Signed 32-bit iterative divider: one restoring-division step per clock,
// MIPS-style HI (remainder) / LO (quotient) result registers.
module div_unit #(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  divControl,
  input  logic [31:0] aIn,
  input  logic [31:0] bIn,
  output logic [31:0] hiOut,
  output logic [31:0] loOut,
  output logic        divBusy,
  output logic        divDone,
  output logic        div0
);

  localparam int CNT_W = $clog2(DIV_STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rem_q;
  logic [31:0]      quo_q;
  logic [31:0]      dvsr_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             busy_q;
  logic             done_q;
  logic             div0_q;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] trial_rem;
  logic [32:0] trial_diff;
  logic        step_keep;
  logic [31:0] rem_d;
  logic [31:0] quo_d;
  logic [31:0] lo_d;
  logic [31:0] hi_d;
  logic        start_cmd;
  logic        abort_cmd;

  // NOTE: every signal in this block is assigned on every path, so no latch is inferred.
  always_comb begin
    start_cmd = (divControl == CMD_START);
    abort_cmd = (divControl == CMD_ABORT);

    // 0x80000000 maps to itself, which is exactly 2^31 read as unsigned.
    a_mag = aIn[31] ? (~aIn + 32'd1) : aIn;
    b_mag = bIn[31] ? (~bIn + 32'd1) : bIn;

    // quo_q doubles as the dividend shift register: its MSB feeds the remainder
    // while the new quotient bit enters at the LSB.
    trial_rem  = {rem_q, quo_q[31]};
    trial_diff = trial_rem - {1'b0, dvsr_q};
    step_keep  = ~trial_diff[32];
    rem_d      = step_keep ? trial_diff[31:0] : trial_rem[31:0];
    quo_d      = {quo_q[30:0], step_keep};

    lo_d = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
    hi_d = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      div0_q <= 1'b0;
      busy_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (start_cmd) begin
            if (bIn == '0) begin
              div0_q <= 1'b1;
            end else begin
              rem_q     <= '0;
              quo_q     <= a_mag;
              dvsr_q    <= b_mag;
              neg_quo_q <= aIn[31] ^ bIn[31];
              neg_rem_q <= aIn[31];
              cnt_q     <= '0;
              state_q   <= CALC;
            end
          end
        end

        CALC: begin
          // Abort wins even on the edge that would complete the final step.
          if (abort_cmd) begin
            state_q <= IDLE;
          end else begin
            busy_q <= 1'b1;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
              state_q <= DONE;
            end
          end
        end

        DONE: begin
          if (!abort_cmd) begin
            lo_q   <= lo_d;
            hi_q   <= hi_d;
            done_q <= 1'b1;
          end
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign hiOut   = hi_q;
  assign loOut   = lo_q;
  assign divBusy = busy_q;
  assign divDone = done_q;
  assign div0    = div0_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table plus scoreboard of expected
// HI/LO results, with hand-written abort, divide-by-zero and reset sequences.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic [1:0]  divControl;
  logic [31:0] aIn;
  logic [31:0] bIn;
  logic [31:0] hiOut;
  logic [31:0] loOut;
  logic        divBusy;
  logic        divDone;
  logic        div0;

  div_unit #(.DIV_STEPS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .divControl (divControl),
    .aIn        (aIn),
    .bIn        (bIn),
    .hiOut      (hiOut),
    .loOut      (loOut),
    .divBusy    (divBusy),
    .divDone    (divDone),
    .div0       (div0)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [63:0] sb_q[$];
  logic [31:0] last_lo;
  logic [31:0] last_hi;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every divDone must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset) begin
      check("done_div0_exclusive", {31'b0, divDone & div0}, 32'd0);
      if (divDone === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", {31'b0, divDone}, 32'd0);
        end else begin
          logic [63:0] exp;
          exp = sb_q.pop_front();
          check("lo_result", loOut, exp[63:32]);
          check("hi_result", hiOut, exp[31:0]);
        end
      end
    end
  end

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
  endfunction

  // Entered at a negedge; returns at the negedge following the sampling edge N.
  task automatic drive_start(input logic [31:0] a, input logic [31:0] b);
    divControl = 2'b01;
    aIn        = a;
    bIn        = b;
    @(negedge clk);
    divControl = 2'b00;
    aIn        = $urandom;
    bIn        = $urandom;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input int poke_at);
    int done_at;
    bit busy_ok;
    done_at = -1;
    busy_ok = 1'b1;
    sb_q.push_back({exp_lo, exp_hi});
    drive_start(a, b);
    for (int k = 1; k <= 40 && done_at < 0; k++) begin
      if (k == poke_at) begin
        divControl = 2'b01;
        aIn        = 32'd9;
        bIn        = 32'd3;
      end
      @(negedge clk);
      if (k == poke_at) divControl = 2'b00;
      if (divBusy !== (k <= 32)) busy_ok = 1'b0;
      if (divDone === 1'b1) done_at = k;
    end
    check("done_latency", 32'(done_at), 32'd33);
    check("busy_profile", {31'b0, busy_ok}, 32'd1);
    last_lo = exp_lo;
    last_hi = exp_hi;
  endtask

  task automatic abort_op(input logic [31:0] a, input logic [31:0] b, input int abort_at);
    bit done_seen;
    done_seen = 1'b0;
    drive_start(a, b);
    repeat (abort_at - 1) @(negedge clk);
    divControl = 2'b11;
    @(negedge clk);
    divControl = 2'b00;
    check("abort_busy_low", {31'b0, divBusy}, 32'd0);
    repeat (40) begin
      @(negedge clk);
      if (divDone === 1'b1) done_seen = 1'b1;
    end
    check("abort_no_done", {31'b0, done_seen}, 32'd0);
    check("abort_lo_kept", loOut, last_lo);
    check("abort_hi_kept", hiOut, last_hi);
  endtask

  initial begin
    vec_t vecs[14];
    logic [31:0] ra, rb, rq, rr;

    vecs[0]  = '{32'd100,       32'd7,         32'd14,        32'd2};
    vecs[1]  = '{32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE};
    vecs[2]  = '{32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2};
    vecs[3]  = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE};
    vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    vecs[5]  = '{32'd0,         32'd5,         32'd0,         32'd0};
    vecs[6]  = '{32'd7,         32'd100,       32'd0,         32'd7};
    vecs[7]  = '{32'hFFFF_FFF9, 32'd100,       32'd0,         32'hFFFF_FFF9};
    vecs[8]  = '{32'h7FFF_FFFF, 32'd2,         32'h3FFF_FFFF, 32'd1};
    vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 32'd1,         32'd0};
    vecs[10] = '{32'h8000_0000, 32'd7,         32'hEDB6_DB6E, 32'hFFFF_FFFE};
    vecs[11] = '{32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0};
    vecs[12] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1,         32'd0};
    vecs[13] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF};

    reset      = 1'b0;
    divControl = 2'b00;
    aIn        = '0;
    bIn        = '0;
    last_lo    = '0;
    last_hi    = '0;

    #3;
    check("reset_hi",   hiOut, 32'd0);
    check("reset_lo",   loOut, 32'd0);
    check("reset_busy", {31'b0, divBusy}, 32'd0);
    check("reset_done", {31'b0, divDone}, 32'd0);
    check("reset_div0", {31'b0, div0}, 32'd0);

    // Release and start on the very first edge.
    @(negedge clk);
    reset = 1'b1;
    run_op(32'd100, 32'd7, 32'd14, 32'd2, 0);

    // Divide by zero issued in the divDone cycle: flag only, results retained.
    drive_start(32'd5, 32'd0);
    check("div0_pulse",     {31'b0, div0}, 32'd1);
    check("div0_busy_low",  {31'b0, divBusy}, 32'd0);
    check("div0_no_done",   {31'b0, divDone}, 32'd0);
    check("div0_lo_kept",   loOut, 32'd14);
    check("div0_hi_kept",   hiOut, 32'd2);
    @(negedge clk);
    check("div0_one_cycle", {31'b0, div0}, 32'd0);
    check("div0_still_idle", {31'b0, divBusy}, 32'd0);

    // Back-to-back table vectors; each start lands in the previous divDone cycle.
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, 0);
    end

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      if (i % 3 == 1) rb = ~rb + 32'd1;
      if (rb == 32'd0) rb = 32'd3;
      model(ra, rb, rq, rr);
      run_op(ra, rb, rq, rr, 0);
    end

    // A start while busy must be ignored.
    run_op(32'd100, 32'd7, 32'd14, 32'd2, 5);

    // Abort in IDLE has no effect.
    divControl = 2'b11;
    @(negedge clk);
    divControl = 2'b00;
    check("idle_abort_busy", {31'b0, divBusy}, 32'd0);
    check("idle_abort_lo",   loOut, 32'd14);
    check("idle_abort_hi",   hiOut, 32'd2);

    abort_op(32'd100, 32'd7, 10);
    abort_op(32'd50,  32'd3, 32);
    abort_op(32'd50,  32'd3, 33);

    // Reset asserted between edges during step 20.
    drive_start(32'd100, 32'd7);
    repeat (20) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset_hi",   hiOut, 32'd0);
    check("midreset_lo",   loOut, 32'd0);
    check("midreset_busy", {31'b0, divBusy}, 32'd0);
    check("midreset_done", {31'b0, divDone}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_op(32'd100, 32'd7, 32'd14, 32'd2, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
